// File: rtl/aes_dec_pkg.sv
// Shared types and GF(2^8) helpers for the AES decryption datapath.
package aes_dec_pkg;
    typedef logic [127:0] state_t;
    typedef logic [31:0]  col_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } imc_state_e;

    localparam logic [7:0] AES_POLY = 8'h1B;

    // Multiply by x in GF(2^8), reducing by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction
endpackage

// File: rtl/inv_mix_columns_seq_if.sv
// Input/output channels of the iterative InvMixColumns engine.
interface inv_mix_columns_seq_if;
    import aes_dec_pkg::*;

    // A transfer happens on a rising edge where valid && ready; the source holds
    // its payload stable while valid && !ready and never waits on ready to raise valid.
    logic   in_valid;
    logic   in_ready;
    state_t in_state;
    logic   out_valid;
    logic   out_ready;
    state_t out_state;

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state
    );
endinterface

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns on one 32-bit column; constants built from xtime chains.
module inv_mix_column
    import aes_dec_pkg::*;
(
    input  col_t col_in,
    output col_t col_out
);
    logic [7:0] a   [4];
    logic [7:0] m09 [4];
    logic [7:0] m0b [4];
    logic [7:0] m0d [4];
    logic [7:0] m0e [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a[i] = col_in[31-8*i -: 8];
        end
        for (int i = 0; i < 4; i++) begin
            m09[i] = xtime(xtime(xtime(a[i]))) ^ a[i];
            m0b[i] = xtime(xtime(xtime(a[i]))) ^ xtime(a[i]) ^ a[i];
            m0d[i] = xtime(xtime(xtime(a[i]))) ^ xtime(xtime(a[i])) ^ a[i];
            m0e[i] = xtime(xtime(xtime(a[i]))) ^ xtime(xtime(a[i])) ^ xtime(a[i]);
        end
        col_out[31:24] = m0e[0] ^ m0b[1] ^ m0d[2] ^ m09[3];
        col_out[23:16] = m09[0] ^ m0e[1] ^ m0b[2] ^ m0d[3];
        col_out[15:8]  = m0d[0] ^ m09[1] ^ m0e[2] ^ m0b[3];
        col_out[7:0]   = m0b[0] ^ m0d[1] ^ m09[2] ^ m0e[3];
    end
endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative InvMixColumns: accepts a 128-bit state, transforms one column per
// cycle (MSB column first), then holds the result until downstream takes it.
module inv_mix_columns_seq
    import aes_dec_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    inv_mix_columns_seq_if.slave  bus,
    output imc_state_e            dbg_state
);
    imc_state_e state_q, state_d;
    logic [1:0] col_cnt;
    state_t     src_reg;
    state_t     res_reg;
    col_t       col_in;
    col_t       col_out;

    always_comb begin
        col_in = '0;
        case (col_cnt)
            2'd0: col_in = src_reg[127:96];
            2'd1: col_in = src_reg[95:64];
            2'd2: col_in = src_reg[63:32];
            2'd3: col_in = src_reg[31:0];
            default: col_in = '0;
        endcase
    end

    inv_mix_column u_col (
        .col_in  (col_in),
        .col_out (col_out)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)      state_d = BUSY;
            BUSY:    if (col_cnt == 2'd3)   state_d = DONE;
            DONE:    if (bus.out_ready)     state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_cnt <= 2'd0;
            src_reg <= '0;
            res_reg <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.in_valid) begin
                src_reg <= bus.in_state;
                col_cnt <= 2'd0;
            end
            // The counter wraps 3->0 on the same edge that enters DONE.
            if (state_q == BUSY) begin
                case (col_cnt)
                    2'd0: res_reg[127:96] <= col_out;
                    2'd1: res_reg[95:64]  <= col_out;
                    2'd2: res_reg[63:32]  <= col_out;
                    2'd3: res_reg[31:0]   <= col_out;
                    default: ;
                endcase
                col_cnt <= col_cnt + 2'd1;
            end
        end
    end

    // Gating with rst_n keeps in_ready low for the whole reset pulse.
    assign bus.in_ready  = (state_q == IDLE) && rst_n;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_state = (state_q == DONE) ? res_reg : '0;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed bench for inv_mix_columns_seq with a GF(2^8) shift-and-add reference.
module tb_inv_mix_columns_seq;
    import aes_dec_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    imc_state_e dbg_state;
    int         n_assert = 0;
    int         n_fail   = 0;

    inv_mix_columns_seq_if bus ();

    inv_mix_columns_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Generic peasant multiply, independent of the xtime-chain structure.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            r[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            r[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            r[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return r;
    endfunction

    // Entries copied from the standard x0B lookup table; bit 8 flags a hit.
    function automatic logic [8:0] tab_0b(input logic [7:0] x);
        case (x)
            8'h00:   return {1'b1, 8'h00};
            8'h01:   return {1'b1, 8'h0b};
            8'h02:   return {1'b1, 8'h16};
            8'h03:   return {1'b1, 8'h1d};
            8'h80:   return {1'b1, 8'hf7};
            8'hff:   return {1'b1, 8'ha3};
            default: return 9'h000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 128'(bus.in_ready), 128'(1));
    endtask

    // Present s for one accept, then count edges after the accept edge until out_valid.
    task automatic run_block(input state_t s, output state_t r, output int lat);
        wait_ready();
        bus.in_state = s;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        r = bus.out_state;
    endtask

    initial begin
        state_t      kin, kout, r, held;
        state_t      bb_in [3];
        logic [127:0] exp_q [$];
        int          lat, acc, nout, last_cyc;
        logic [8:0]  t;

        kin  = 128'h8e4da1bc_d5d5d7d6_4d7ebdf8_01010101;
        kout = 128'hdb135345_d4d4d4d5_2d26314c_01010101;

        // Clock / reset
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_state  = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_out_state", bus.out_state, '0);
        chk("rst_fsm", 128'(dbg_state), 128'(IDLE));
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 128'(bus.in_ready), 128'(1));

        // Known vector with latency
        run_block(kin, r, lat);
        chk("known_latency", 128'(lat), 128'(4));
        chk("known_vec", r, kout);
        chk("known_vs_model", r, model(kin));
        chk("valid_ready_excl", 128'(bus.in_ready), 128'(0));
        @(negedge clk);
        chk("known_after_out_valid", 128'(bus.out_valid), 128'(0));
        chk("known_after_in_ready", 128'(bus.in_ready), 128'(1));
        chk("known_after_out_state", bus.out_state, '0);

        // Backpressure
        bus.out_ready = 1'b0;
        run_block(kin, held, lat);
        chk("bp_vec", held, kout);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold_state", bus.out_state, kout);
            chk("bp_hold_valid", 128'(bus.out_valid), 128'(1));
            chk("bp_in_ready", 128'(bus.in_ready), 128'(0));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 128'(bus.out_valid), 128'(0));
        chk("bp_release_in_ready", 128'(bus.in_ready), 128'(1));

        // Input changes while BUSY must not be sampled or accepted
        wait_ready();
        bus.in_state = kin;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_state = '1;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        bus.in_valid = 1'b0;
        chk("busy_change_vec", bus.out_state, kout);
        chk("busy_change_latency", 128'(lat), 128'(4));
        @(negedge clk);
        chk("busy_change_no_accept", 128'(dbg_state), 128'(IDLE));
        repeat (6) @(negedge clk);
        chk("busy_change_no_output", 128'(bus.out_valid), 128'(0));

        // Reset in the middle of BUSY
        wait_ready();
        bus.in_state = kin;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("midrst_out_state", bus.out_state, '0);
        chk("midrst_in_ready", 128'(bus.in_ready), 128'(0));
        chk("midrst_fsm", 128'(dbg_state), 128'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_release_in_ready", 128'(bus.in_ready), 128'(1));
        nout = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) nout++;
        end
        chk("midrst_no_spurious", 128'(nout), 128'(0));

        // Multiplier sweep over every byte in the top position
        for (int x = 0; x < 256; x++) begin
            run_block({8'(x), 120'h0}, r, lat);
            chk("sweep", r, model({8'(x), 120'h0}));
            t = tab_0b(8'(x));
            if (t[8]) chk("x0b_table", 128'(r[103:96]), 128'(t[7:0]));
        end
        @(negedge clk);

        // Back-to-back with in_valid held high
        bb_in[0] = 128'h00112233_44556677_8899aabb_ccddeeff;
        bb_in[1] = kin;
        bb_in[2] = 128'hdeadbeef_01234567_fedcba98_a5a55a5a;
        acc      = 0;
        nout     = 0;
        last_cyc = -1;
        wait_ready();
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (bus.out_valid === 1'b1) begin
                chk("b2b_out", bus.out_state, (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx);
                if (last_cyc >= 0) chk("b2b_spacing", 128'(cyc - last_cyc), 128'(6));
                last_cyc = cyc;
                nout++;
            end
            if (bus.in_ready === 1'b1) begin
                if (acc < 3) begin
                    bus.in_state = bb_in[acc];
                    bus.in_valid = 1'b1;
                    exp_q.push_back(model(bb_in[acc]));
                    acc++;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("b2b_count", 128'(nout), 128'(3));
        chk("b2b_queue_empty", 128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/inv_mix_columns_seq.md
# inv_mix_columns_seq

Iterative InvMixColumns engine for the AES decryption datapath. It accepts one 128-bit state over a valid/ready handshake and processes one 32-bit column per cycle. Each column uses the GF(2^8) constant multipliers ×09, ×0B, ×0D and ×0E. The block holds the result until downstream accepts it. It sits between AddRoundKey and the next round's InvShiftRows/InvSubBytes, and consumes the ×0B and sibling constant-multiply products.

## Interface
- No parameters; widths are fixed by AES.
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  in_state is valid
- in_ready  output  1  block can accept a state; high only in IDLE
- in_state  input  128  state, FIPS-197 byte order: [127:120]=s(0,0), [119:112]=s(1,0), …, [7:0]=s(3,3)
- out_valid  output  1  out_state is valid
- out_ready  input  1  downstream accepts out_state
- out_state  output  128  InvMixColumns(in_state), same byte order

## Operation
- FSM states:
  - IDLE → BUSY on in_valid && in_ready. in_state is captured into src_reg and col_cnt is set to 0.
  - BUSY: on each cycle, column col_cnt = src_reg[127-32*col_cnt -: 32] goes through inv_mix_column. The result is written to the same slice of res_reg, then col_cnt increments.
  - BUSY → DONE on the edge that writes col_cnt==3.
  - DONE → IDLE on out_valid && out_ready.
- Column math, with a0..a3 the column bytes from MSB and ⊕ = XOR:
  - b0 = 0E·a0 ⊕ 0B·a1 ⊕ 0D·a2 ⊕ 09·a3
  - b1 = 09·a0 ⊕ 0E·a1 ⊕ 0B·a2 ⊕ 0D·a3
  - b2 = 0D·a0 ⊕ 09·a1 ⊕ 0E·a2 ⊕ 0B·a3
  - b3 = 0B·a0 ⊕ 0D·a1 ⊕ 09·a2 ⊕ 0E·a3
- All products are 8-bit values in GF(2^8) modulo x^8+x^4+x^3+x+1.
- The ×0B product must be bit-identical to the existing ×0B lookup for all 256 inputs.
- in_ready is 1 only in IDLE. in_valid is ignored in BUSY and DONE, and the held input is not sampled.
- out_valid is 1 only in DONE. out_state = res_reg and is stable while out_valid && !out_ready.
- out_state is 0 when out_valid is 0. Stale data must not leak.
- Reset values (async on rst_n low):
  - FSM = IDLE, col_cnt = 0, src_reg = 0, res_reg = 0.
  - in_ready = 1 after reset releases; in_ready = 0 while rst_n is low.
  - out_valid = 0, out_state = 0.
- Reset asserted mid-BUSY or mid-DONE discards the block. No output is produced for it.

## Timing
- Accept edge is E0. Columns 0..3 are written at E1..E4. out_valid rises immediately after E4.
- Latency from accept to out_valid is 4 cycles.
- With out_ready held at 1:
  - the output handshake happens at E5;
  - in_ready is high after E5;
  - the next accept is at E6;
  - throughput is one block per 6 cycles.
- Backpressure: DONE is held indefinitely and col_cnt does not move.
- out_valid and in_ready are never high in the same cycle.
- col_cnt is 2 bits and wraps 3→0 on the DONE transition.

## Structure
- Shared package aes_dec_pkg holds:
  - state_t (logic [127:0]), col_t (logic [31:0]);
  - the FSM enum imc_state_e {IDLE, BUSY, DONE};
  - the AES polynomial constant 8'h1B;
  - the xtime function.
- Sub-module inv_mix_column: combinational, col_t in, col_t out. Implements ×09/×0B/×0D/×0E as xtime chains.
- The top holds the FSM, col_cnt, src_reg, res_reg and the handshake logic.

## Test plan
- Known vector, out_ready=1: in_state = 8e4da1bc_d5d5d7d6_4d7ebdf8_01010101 → out_state = db135345_d4d4d4d5_2d26314c_01010101, out_valid exactly 4 cycles after the accept edge.
- Backpressure: same vector with out_ready=0 for 10 cycles after out_valid → out_state held constant and in_ready=0 throughout. Raise out_ready → one transfer, then in_ready=1 on the next cycle.
- Input change during BUSY: toggle in_state to all-FF while BUSY → output still matches the captured vector, with no second accept.
- Reset mid-operation: drop rst_n at E2 → out_valid=0 and out_state=0 immediately, in_ready=1 after release, and no spurious output afterward.
- Multiplier sweep: for each byte x, drive column {x,0,0,0} → out column = {0E·x, 09·x, 0D·x, 0B·x}, checked against a GF(2^8) reference model. The ×0B byte is also checked against the existing table.
- Back-to-back: in_valid held high with 3 distinct states → exactly 3 outputs, in order, spaced 6 cycles apart, each matching the model.
